// File: rtl/pkt_loop_buf.sv
// -----------------------------------------------------------------------------
// pkt_loop_buf
//   Packet loop stage between the parallel UART receiver and sender. Each
//   received packet is transformed at push time, queued in a packet FIFO, then
//   replayed to the sender under a small handshake FSM. The stage also drives
//   display data for the segment-LED driver and keeps a count of dropped packets.
//
// Parameters
//   PKT_BYTES    packet width in bytes (>= 3)
//   DEPTH        FIFO depth in packets (power of 2, >= 2)
//   BUSY_TIMEOUT cycles to wait for tx_busy after send_en
//
// Ports
//   sys_clk     in   system clock, rising edge
//   sys_rst_n   in   synchronous active-low reset
//   recv_done   in   one-cycle pulse, recv_data valid
//   recv_data   in   received packet, byte0 = bits[7:0]
//   mode        in   transform select (0 echo, 1 reverse, 2 +1, 3 invert)
//   tx_busy     in   sender busy
//   send_en     out  one-cycle send start pulse
//   send_data   out  packet to send, stable until back in IDLE
//   disp_data   out  {byte0,byte1,byte2} of the last sent packet
//   disp_valid  out  one-cycle pulse when disp_data updates
//   fifo_level  out  packets queued (0..DEPTH)
//   drop_cnt    out  dropped packets, saturating at 255
//
// Optional feature macro: PKT_LOOP_CHECKSUM_EN
//   When defined, the last byte of each packet is an XOR checksum over the
//   other bytes. Bad packets are dropped; good packets get the checksum byte
//   regenerated before the transform.
// -----------------------------------------------------------------------------
module pkt_loop_buf #(
    parameter int PKT_BYTES    = 16,
    parameter int DEPTH        = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       recv_done,
    input  logic [PKT_BYTES*8-1:0]     recv_data,
    input  logic [1:0]                 mode,
    input  logic                       tx_busy,
    output logic                       send_en,
    output logic [PKT_BYTES*8-1:0]     send_data,
    output logic [23:0]                disp_data,
    output logic                       disp_valid,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [7:0]                 drop_cnt
);

    localparam int W  = PKT_BYTES * 8;
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   LVL_MAX = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] CNT_ONE = TW'(1);
    localparam logic [TW-1:0] CNT_END = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

    // Per-byte transform; bytes are handled independently (no carries).
    function automatic logic [W-1:0] f_xform(input logic [W-1:0] d, input logic [1:0] m);
        logic [W-1:0] r;
        r = d;
        for (int i = 0; i < PKT_BYTES; i++) begin
            case (m)
                2'd0:    r[i*8 +: 8] = d[i*8 +: 8];
                2'd1:    r[i*8 +: 8] = d[(PKT_BYTES-1-i)*8 +: 8];
                2'd2:    r[i*8 +: 8] = d[i*8 +: 8] + 8'd1;
                2'd3:    r[i*8 +: 8] = ~d[i*8 +: 8];
                default: r[i*8 +: 8] = d[i*8 +: 8];
            endcase
        end
        return r;
    endfunction

    // XOR of every byte except the last one.
    function automatic logic [7:0] f_xor_payload(input logic [W-1:0] d);
        logic [7:0] x;
        x = 8'd0;
        for (int i = 0; i < PKT_BYTES - 1; i++) begin
            x = x ^ d[i*8 +: 8];
        end
        return x;
    endfunction

    state_t          r_state;
    logic [W-1:0]    r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [TW-1:0]   r_to_cnt;

    logic            w_csum_ok;
    logic [W-1:0]    w_pre;
    logic [W-1:0]    w_xform;
    logic [W-1:0]    w_head;
    logic            w_pop;
    logic            w_full;
    logic            w_push;
    logic            w_drop;

`ifdef PKT_LOOP_CHECKSUM_EN
    assign w_csum_ok = (f_xor_payload(recv_data) == recv_data[W-1 -: 8]);
    assign w_pre     = {f_xor_payload(recv_data), recv_data[W-9:0]};
`else
    assign w_csum_ok = 1'b1;
    assign w_pre     = recv_data;
`endif

    assign w_xform = f_xform(w_pre, mode);
    assign w_head  = r_mem[r_rd_ptr];
    assign w_pop   = (r_state == S_LOAD);
    assign w_full  = (fifo_level == LVL_MAX);
    // A push into a full FIFO is still accepted when the head leaves this cycle.
    assign w_push  = recv_done & w_csum_ok & (~w_full | w_pop);
    assign w_drop  = recv_done & ~w_push;

    // Packet storage; contents are don't-care until written, so no reset.
    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_xform;
        end
    end

    // FIFO pointers, occupancy and drop counter.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            fifo_level <= '0;
            drop_cnt   <= 8'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   fifo_level <= fifo_level + LVL_ONE;
                2'b01:   fifo_level <= fifo_level - LVL_ONE;
                default: fifo_level <= fifo_level;
            endcase
            if (w_drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Send FSM with registered outputs; send_en/disp_valid are high during START.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state    <= S_IDLE;
            r_to_cnt   <= '0;
            send_en    <= 1'b0;
            send_data  <= '0;
            disp_data  <= 24'd0;
            disp_valid <= 1'b0;
        end else begin
            send_en    <= 1'b0;
            disp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if ((fifo_level != '0) && !tx_busy) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    send_data  <= w_head;
                    disp_data  <= {w_head[7:0], w_head[15:8], w_head[23:16]};
                    send_en    <= 1'b1;
                    disp_valid <= 1'b1;
                    r_state    <= S_START;
                end
                S_START: begin
                    r_to_cnt <= '0;
                    r_state  <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    // A sender that never answers is abandoned; no retry.
                    if (tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_to_cnt == CNT_END) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + CNT_ONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_loop_buf.sv
// -----------------------------------------------------------------------------
// tb_pkt_loop_buf
//   Directed bench for pkt_loop_buf with default parameters
//   (PKT_BYTES=16, DEPTH=4, BUSY_TIMEOUT=15). Inputs change and outputs are
//   sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_pkt_loop_buf;

    logic         sys_clk;
    logic         sys_rst_n;
    logic         recv_done;
    logic [127:0] recv_data;
    logic [1:0]   mode;
    logic         tx_busy;
    logic         send_en;
    logic [127:0] send_data;
    logic [23:0]  disp_data;
    logic         disp_valid;
    logic [2:0]   fifo_level;
    logic [7:0]   drop_cnt;

    int total;
    int bad;

    pkt_loop_buf #(
        .PKT_BYTES    (16),
        .DEPTH        (4),
        .BUSY_TIMEOUT (15)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .recv_done  (recv_done),
        .recv_data  (recv_data),
        .mode       (mode),
        .tx_busy    (tx_busy),
        .send_en    (send_en),
        .send_data  (send_data),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [127:0] d, input logic [1:0] m);
        recv_done = 1'b1;
        recv_data = d;
        mode      = m;
        tick();
        recv_done = 1'b0;
    endtask

    // From IDLE with data queued: two edges to START.
    task automatic expect_send(input string tag, input logic [127:0] d);
        tick();
        chk({tag, "_early"}, {127'd0, send_en}, 128'd0);
        tick();
        chk({tag, "_en"}, {127'd0, send_en}, 128'd1);
        chk({tag, "_data"}, send_data, d);
    endtask

    // From START: sender answers at once, FSM returns to IDLE.
    task automatic handshake(input string tag);
        tick();
        chk({tag, "_en_one_cycle"}, {127'd0, send_en}, 128'd0);
        tx_busy = 1'b1;
        tick();
        tx_busy = 1'b0;
        tick();
    endtask

    localparam logic [127:0] P_ECHO = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] P_T    = 128'hA50000000000000000000000004812FF;
    localparam logic [127:0] P_T_M2 = 128'hA6010101010101010101010101491300;
    localparam logic [127:0] P_T_M1 = 128'hFF1248000000000000000000000000A5;
    localparam logic [127:0] P_T_M3 = 128'h5AFFFFFFFFFFFFFFFFFFFFFFFFB7ED00;

    initial begin
        logic [7:0]   b;
        logic [127:0] q;
        logic [127:0] x;
        int           n;
        int           en_seen;

        total     = 0;
        bad       = 0;
        sys_rst_n = 1'b0;
        recv_done = 1'b0;
        recv_data = 128'd0;
        mode      = 2'd0;
        tx_busy   = 1'b0;

        // ---- reset state
        tick();
        tick();
        chk("rst_send_en",    {127'd0, send_en},    128'd0);
        chk("rst_send_data",  send_data,            128'd0);
        chk("rst_disp_data",  {104'd0, disp_data},  128'd0);
        chk("rst_disp_valid", {127'd0, disp_valid}, 128'd0);
        chk("rst_fifo_level", {125'd0, fifo_level}, 128'd0);
        chk("rst_drop_cnt",   {120'd0, drop_cnt},   128'd0);
        sys_rst_n = 1'b1;
        tick();

        // ---- echo, 3-cycle latency
        push(P_ECHO, 2'd0);
        chk("echo_level", {125'd0, fifo_level}, 128'd1);
        expect_send("echo", P_ECHO);
        chk("echo_disp", {104'd0, disp_data}, {104'd0, 24'h000102});
        chk("echo_disp_valid", {127'd0, disp_valid}, 128'd1);
        chk("echo_level_after_pop", {125'd0, fifo_level}, 128'd0);
        tick();
        chk("echo_disp_valid_one", {127'd0, disp_valid}, 128'd0);
        tx_busy = 1'b1;
        tick();
        tx_busy = 1'b0;
        tick();
        chk("echo_data_hold", send_data, P_ECHO);

        // ---- transforms
        push(P_T, 2'd2);
        expect_send("m2", P_T_M2);
        chk("m2_disp", {104'd0, disp_data}, {104'd0, 24'h001349});
        handshake("m2");
        push(P_T, 2'd1);
        expect_send("m1", P_T_M1);
        chk("m1_disp", {104'd0, disp_data}, {104'd0, 24'hA50000});
        handshake("m1");
        push(P_T, 2'd3);
        expect_send("m3", P_T_M3);
        chk("m3_disp", {104'd0, disp_data}, {104'd0, 24'h00EDB7});
        handshake("m3");

        // ---- busy timeout: next packet leaves 18 edges after START, no retry
        push({16{8'h41}}, 2'd0);
        expect_send("to_a", {16{8'h41}});
        tick();
        push({16{8'h42}}, 2'd0);
        n = 2;
        while (send_en !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("timeout_gap", n, 128'd18);
        chk("timeout_no_retry", send_data, {16{8'h42}});
        handshake("to_b");

        // ---- long busy: next send only after tx_busy falls
        push({16{8'h43}}, 2'd0);
        push({16{8'h44}}, 2'd0);
        tick();
        chk("hs_c_en", {127'd0, send_en}, 128'd1);
        chk("hs_c_data", send_data, {16{8'h43}});
        tick();
        tx_busy = 1'b1;
        en_seen = 0;
        for (int i = 0; i < 101; i++) begin
            tick();
            if (send_en === 1'b1) en_seen++;
        end
        chk("hs_no_send_while_busy", en_seen, 128'd0);
        tx_busy = 1'b0;
        tick();
        chk("hs_idle_en", {127'd0, send_en}, 128'd0);
        expect_send("hs_d", {16{8'h44}});
        handshake("hs_d");

        // ---- overflow and full push+pop
        tx_busy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            b = 8'h10 + 8'(k);
            push({16{b}}, 2'd0);
        end
        chk("ovf_level", {125'd0, fifo_level}, 128'd4);
        chk("ovf_drop", {120'd0, drop_cnt}, 128'd2);
        chk("ovf_no_send", {127'd0, send_en}, 128'd0);
        tx_busy = 1'b0;
        tick();
        push({16{8'h1F}}, 2'd0);
        chk("full_pp_en", {127'd0, send_en}, 128'd1);
        chk("full_pp_data", send_data, {16{8'h10}});
        chk("full_pp_level", {125'd0, fifo_level}, 128'd4);
        chk("full_pp_drop", {120'd0, drop_cnt}, 128'd2);
        handshake("ovf0");
        for (int k = 1; k < 4; k++) begin
            b = 8'h10 + 8'(k);
            expect_send("ovf_order", {16{b}});
            handshake("ovf");
        end
        expect_send("ovf_last", {16{8'h1F}});
        handshake("ovf_last");
        chk("ovf_drained", {125'd0, fifo_level}, 128'd0);

        // ---- reset in WAIT_DONE with 3 packets queued
        push({16{8'h50}}, 2'd0);
        tick();
        tick();
        tick();
        tx_busy = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            b = 8'h51 + 8'(k);
            push({16{b}}, 2'd0);
        end
        chk("rst2_level_before", {125'd0, fifo_level}, 128'd3);
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        tx_busy   = 1'b0;
        chk("rst2_level", {125'd0, fifo_level}, 128'd0);
        chk("rst2_drop", {120'd0, drop_cnt}, 128'd0);
        chk("rst2_data", send_data, 128'd0);
        en_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (send_en === 1'b1) en_seen++;
        end
        chk("rst2_no_send", en_seen, 128'd0);

        // ---- packet whose last byte is not the XOR of the others
        x = {8'h00, P_T[119:0]};
`ifdef PKT_LOOP_CHECKSUM_EN
        push(x, 2'd0);
        chk("csum_bad_drop", {120'd0, drop_cnt}, 128'd1);
        chk("csum_bad_level", {125'd0, fifo_level}, 128'd0);
        en_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (send_en === 1'b1) en_seen++;
        end
        chk("csum_bad_no_send", en_seen, 128'd0);
`else
        push(x, 2'd0);
        expect_send("nocsum_payload", x);
        chk("nocsum_drop", {120'd0, drop_cnt}, 128'd0);
        handshake("nocsum");
`endif

        // ---- drop counter saturates
        tx_busy = 1'b1;
        for (int k = 0; k < 300; k++) begin
            push({16{8'h60}}, 2'd0);
        end
        chk("sat_drop", {120'd0, drop_cnt}, 128'd255);
        chk("sat_level", {125'd0, fifo_level}, 128'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
